// File: rtl/rv_multicycle_ctrl_if.sv
// Instruction/data memory handshake bundle between the control sequencer and the memories.
interface rv_multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch, decode, exec, mem, writeback, with
// memory-wait timeout and sticky halt status.
module rv_multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rv_multicycle_ctrl_if.master mem,
  input  logic                 branch_taken,
  output logic [31:0]          ir,
  output logic [2:0]           imm_sel,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 halted,
  output logic                 illegal,
  output logic                 bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timeout_hit;
  logic               set_illegal, set_bus_err;
  logic [6:0]         opc;
  logic is_opimm, is_load, is_jalr, is_store, is_branch, is_lui;
  logic is_auipc, is_jal, is_op, is_fence, is_system, is_legal;

  // Opcode class decode of the latched instruction
  always_comb begin
    opc       = ir[6:0];
    is_opimm  = (opc == OPC_OP_IMM);
    is_load   = (opc == OPC_LOAD);
    is_jalr   = (opc == OPC_JALR);
    is_store  = (opc == OPC_STORE);
    is_branch = (opc == OPC_BRANCH);
    is_lui    = (opc == OPC_LUI);
    is_auipc  = (opc == OPC_AUIPC);
    is_jal    = (opc == OPC_JAL);
    is_op     = (opc == OPC_OP);
    is_fence  = (opc == OPC_FENCE);
    is_system = (opc == OPC_SYSTEM);
    is_legal  = is_opimm | is_load | is_jalr | is_store | is_branch | is_lui |
                is_auipc | is_jal | is_op | is_fence;
  end

  always_comb begin
    imm_sel = 3'd0;
    case (opc)
      OPC_STORE:           imm_sel = 3'd1;
      OPC_BRANCH:          imm_sel = 3'd2;
      OPC_LUI, OPC_AUIPC:  imm_sel = 3'd3;
      OPC_JAL:             imm_sel = 3'd4;
      default:             imm_sel = 3'd0;
    endcase
  end

  // Counter holds the number of already-unanswered cycles in the current state
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(wait_cnt) + 32'd1) == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RST;
      ir       <= 32'd0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && mem.imem_ready) ir <= mem.imem_rdata;
      wait_cnt <= (state_next != state) ? '0 : wait_cnt + CNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = 2'd0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    halted       = 1'b0;
    set_illegal  = 1'b0;
    set_bus_err  = 1'b0;
    case (state)
      ST_RST: state_next = ST_FETCH;
      ST_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          state_next  = ST_HALT;
          set_bus_err = 1'b1;
        end
      end
      ST_DECODE: begin
        if (is_system) begin
          state_next = ST_HALT;
        end else if (!is_legal) begin
          state_next  = ST_HALT;
          set_illegal = 1'b1;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_WB;
        if (is_op || is_opimm) begin
          alu_op    = 2'd1;
          alu_src_b = is_opimm;
        end else if (is_lui) begin
          alu_op    = 2'd3;
          alu_src_b = 1'b1;
        end else if (is_auipc || is_jal) begin
          alu_src_a = 1'b1;
          alu_src_b = 1'b1;
        end else if (is_jalr) begin
          alu_src_b = 1'b1;
        end else if (is_load || is_store) begin
          alu_src_b  = 1'b1;
          state_next = ST_MEM;
        end else if (is_branch) begin
          alu_op     = 2'd2;
          pc_we      = 1'b1;
          pc_src     = branch_taken ? 2'd1 : 2'd0;
          state_next = ST_FETCH;
        end else if (is_fence) begin
          pc_we      = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_HALT;
        end
      end
      ST_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = is_store;
        if (mem.dmem_ready) begin
          if (is_store) begin
            pc_we      = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timeout_hit) begin
          state_next  = ST_HALT;
          set_bus_err = 1'b1;
        end
      end
      ST_WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        wb_sel     = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        pc_src     = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        state_next = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_next = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: directed vector table, random instruction stream against
// a cycle-trace reference model, and halt/timeout/reset sequences.
module tb_rv_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_multicycle_ctrl_if mif();
  logic        branch_taken;
  logic [31:0] ir;
  logic [2:0]  imm_sel;
  logic        alu_src_a, alu_src_b, pc_we, rf_we, halted, illegal, bus_err;
  logic [1:0]  alu_op, pc_src, wb_sel;

  rv_multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mif.master), .branch_taken(branch_taken),
    .ir(ir), .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel),
    .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  typedef struct packed {
    logic [31:0] ir;
    logic [2:0]  imm;
    logic        ireq, dreq, dwe, a, b;
    logic [1:0]  op;
    logic        pcwe;
    logic [1:0]  pcsrc;
    logic        rfwe;
    logic [1:0]  wbsel;
    logic        halted, illegal, bus_err;
  } obs_t;

  typedef struct {
    obs_t        e;
    logic        iready, dready, taken;
    logic [31:0] rdata;
  } step_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          fd, md;
    logic        taken;
    int          cycles;
    logic [2:0]  imm;
    logic [3:0]  exec_alu;
    logic [1:0]  pcsrc;
    logic        rfwe;
    logic [1:0]  wbsel;
    int          dreq_cyc;
    logic        dwe;
  } vec_t;

  int checks = 0;
  int failures = 0;
  step_t q[$];
  logic [31:0] prev_ir = 32'd0;
  int tr_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.ir = ir; o.imm = imm_sel; o.ireq = mif.imem_req; o.dreq = mif.dmem_req;
    o.dwe = mif.dmem_we; o.a = alu_src_a; o.b = alu_src_b; o.op = alu_op;
    o.pcwe = pc_we; o.pcsrc = pc_src; o.rfwe = rf_we; o.wbsel = wb_sel;
    o.halted = halted; o.illegal = illegal; o.bus_err = bus_err;
    return o;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b0110111, 7'b0010111: return 3'd3;
      7'b1101111:             return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  function automatic step_t blank(input logic [31:0] instr, input logic taken);
    step_t s;
    s.e = '0; s.iready = 1'b0; s.dready = 1'b0; s.taken = taken; s.rdata = instr;
    s.e.ir = instr; s.e.imm = imm_of(instr[6:0]);
    return s;
  endfunction

  // Expected per-cycle trace of one instruction, from the instruction's class
  task automatic build(input logic [31:0] instr, input int fd, input int md, input logic taken);
    step_t s;
    logic [6:0] o = instr[6:0];
    bit ld = (o == 7'b0000011), st = (o == 7'b0100011), br = (o == 7'b1100011);
    bit fe = (o == 7'b0001111), jal = (o == 7'b1101111), jalr = (o == 7'b1100111);
    bit sys = (o == 7'b1110011);
    bit known = ld || st || br || fe || jal || jalr || (o == 7'b0010011) ||
                (o == 7'b0110011) || (o == 7'b0110111) || (o == 7'b0010111);
    for (int i = 0; i <= fd; i++) begin
      s = blank(prev_ir, taken); s.rdata = instr;
      s.e.ireq = 1'b1; s.iready = (i == fd);
      q.push_back(s);
    end
    prev_ir = instr;
    q.push_back(blank(instr, taken));
    if (sys || !known) begin
      for (int i = 0; i < 3; i++) begin
        s = blank(instr, taken); s.e.halted = 1'b1; s.e.illegal = !sys;
        q.push_back(s);
      end
      return;
    end
    s = blank(instr, taken);
    case (o)
      7'b0010011: begin s.e.op = 2'd1; s.e.b = 1'b1; end
      7'b0110011: s.e.op = 2'd1;
      7'b0110111: begin s.e.op = 2'd3; s.e.b = 1'b1; end
      7'b0010111, 7'b1101111: begin s.e.a = 1'b1; s.e.b = 1'b1; end
      7'b1100111, 7'b0000011, 7'b0100011: s.e.b = 1'b1;
      7'b1100011: begin s.e.op = 2'd2; s.e.pcwe = 1'b1; s.e.pcsrc = taken ? 2'd1 : 2'd0; end
      default: s.e.pcwe = 1'b1;
    endcase
    q.push_back(s);
    if (ld || st) begin
      for (int i = 0; i <= md; i++) begin
        s = blank(instr, taken); s.e.dreq = 1'b1; s.e.dwe = st; s.dready = (i == md);
        s.e.pcwe = st && (i == md);
        q.push_back(s);
      end
    end
    if (!(br || fe || st)) begin
      s = blank(instr, taken); s.e.rfwe = 1'b1; s.e.pcwe = 1'b1;
      s.e.wbsel = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
      s.e.pcsrc = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);
      q.push_back(s);
    end
  endtask

  task automatic play();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      mif.imem_rdata = s.rdata; mif.imem_ready = s.iready;
      mif.dmem_ready = s.dready; branch_taken = s.taken;
      #1;
      chk($sformatf("trace%0d", tr_n), 64'(sample()), 64'(s.e));
      tr_n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
    #1;
    chk("async_reset", 64'(sample()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_state", 64'(sample()), 64'd0);
    @(negedge clk);
    prev_ir = 32'd0;
  endtask

  // Reactive memory responder; measures latency and key strobes of one instruction
  task automatic run_vec(input vec_t v);
    int cyc = 0, iw = 0, dw = 0, dreq_n = 0;
    logic dwe_seen = 1'b0, done = 1'b0, rf_at = 1'b0;
    logic [3:0] alu = 4'd0;
    logic [2:0] imm_at = 3'd0;
    logic [1:0] pcs_at = 2'd0, wbs_at = 2'd0;
    while (!done && cyc < 40) begin
      mif.imem_rdata = v.instr; branch_taken = v.taken;
      mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
      #1;
      if (mif.imem_req) begin mif.imem_ready = (iw == v.fd); iw++; end
      if (mif.dmem_req) begin
        mif.dmem_ready = (dw == v.md); dw++; dreq_n++;
        if (mif.dmem_we) dwe_seen = 1'b1;
      end
      #1;
      cyc++;
      if (cyc == v.fd + 3) alu = {alu_src_a, alu_src_b, alu_op};
      if (pc_we) begin
        done = 1'b1; imm_at = imm_sel; pcs_at = pc_src; rf_at = rf_we; wbs_at = wb_sel;
      end
      @(negedge clk);
    end
    chk({v.name, "_retired"}, 64'(done), 64'd1);
    chk({v.name, "_cycles"}, 64'(cyc), 64'(v.cycles));
    chk({v.name, "_imm_sel"}, 64'(imm_at), 64'(v.imm));
    chk({v.name, "_exec_alu"}, 64'(alu), 64'(v.exec_alu));
    chk({v.name, "_pc_src"}, 64'(pcs_at), 64'(v.pcsrc));
    chk({v.name, "_rf_we"}, 64'(rf_at), 64'(v.rfwe));
    chk({v.name, "_wb_sel"}, 64'(wbs_at), 64'(v.wbsel));
    chk({v.name, "_dreq_cycles"}, 64'(dreq_n), 64'(v.dreq_cyc));
    chk({v.name, "_dmem_we"}, 64'(dwe_seen), 64'(v.dwe));
  endtask

  vec_t vt[11];
  logic [6:0] opcs[10] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                           7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111};

  initial begin
    // name, instr, fetch wait, mem wait, taken, cycles, imm, {a,b,op}, pc_src, rf_we, wb_sel, dreq cycles, dmem_we
    vt[0]  = '{"addi",    32'h00500093, 0, 0, 1'b0, 4, 3'd0, 4'b0101, 2'd0, 1'b1, 2'd0, 0, 1'b0};
    vt[1]  = '{"lw",      32'h0000A103, 0, 3, 1'b0, 8, 3'd0, 4'b0100, 2'd0, 1'b1, 2'd1, 4, 1'b0};
    vt[2]  = '{"beq_t",   32'h00208463, 0, 0, 1'b1, 3, 3'd2, 4'b0010, 2'd1, 1'b0, 2'd0, 0, 1'b0};
    vt[3]  = '{"beq_nt",  32'h00208463, 0, 0, 1'b0, 3, 3'd2, 4'b0010, 2'd0, 1'b0, 2'd0, 0, 1'b0};
    vt[4]  = '{"jalr",    32'h000080E7, 0, 0, 1'b0, 4, 3'd0, 4'b0100, 2'd2, 1'b1, 2'd2, 0, 1'b0};
    vt[5]  = '{"sw",      32'h0020A023, 0, 0, 1'b0, 4, 3'd1, 4'b0100, 2'd0, 1'b0, 2'd0, 1, 1'b1};
    vt[6]  = '{"jal",     32'h008000EF, 0, 0, 1'b0, 4, 3'd4, 4'b1100, 2'd1, 1'b1, 2'd2, 0, 1'b0};
    vt[7]  = '{"lui",     32'h123450B7, 0, 0, 1'b0, 4, 3'd3, 4'b0111, 2'd0, 1'b1, 2'd0, 0, 1'b0};
    vt[8]  = '{"fence",   32'h0000000F, 0, 0, 1'b0, 3, 3'd0, 4'b0000, 2'd0, 1'b0, 2'd0, 0, 1'b0};
    vt[9]  = '{"add_w3",  32'h002081B3, 3, 0, 1'b0, 7, 3'd0, 4'b0001, 2'd0, 1'b1, 2'd0, 0, 1'b0};
    vt[10] = '{"auipc_w2",32'h00001097, 2, 0, 1'b0, 6, 3'd3, 4'b1100, 2'd0, 1'b1, 2'd0, 0, 1'b0};

    branch_taken = 1'b0; mif.imem_rdata = 32'd0;
    mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    foreach (vt[i]) run_vec(vt[i]);
    prev_ir = vt[10].instr;

    // Random legal instruction stream, fetch/mem waits up to the timeout boundary
    for (int n = 0; n < 150; n++) begin
      logic [31:0] rnd;
      int idx;
      rnd = $urandom();
      idx = int'($urandom_range(9));
      build({rnd[31:7], opcs[idx]}, int'($urandom_range(3)), int'($urandom_range(3)),
            1'($urandom_range(1)));
      play();
    end

    // Unsupported opcode halts with illegal; then ECALL halts without it
    build(32'h0000007F, 1, 0, 1'b0);
    play();
    do_reset();
    build(32'h00000073, 0, 0, 1'b0);
    play();
    do_reset();

    // Fetch never answered: four waiting cycles then bus error halt
    begin
      step_t s;
      for (int i = 0; i < 4; i++) begin
        s = blank(32'd0, 1'b0); s.e.ireq = 1'b1; q.push_back(s);
      end
      for (int i = 0; i < 3; i++) begin
        s = blank(32'd0, 1'b0); s.e.halted = 1'b1; s.e.bus_err = 1'b1; q.push_back(s);
      end
      play();
    end
    do_reset();
    build(32'h00500093, 0, 0, 1'b0);
    play();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
